addsub_div_seq: RTL and testbench
=================================

Name: addsub_div_seq

Overview:
- Sequencing controller that performs unsigned 16-bit restoring division by time-multiplexing the shared 16-bit add/subtract datapath.
- The datapath is instantiated outside this block. Its carry-in doubles as the subtract select: the datapath XORs B with carry-in internally.
- This block owns operand muxing, partial-remainder and quotient registers, the iteration counter and the start/done handshake toward the CPU control unit.

Parameters:
- WIDTH, 16, operand/result width; fixed to the datapath width, only 16 is supported.
- ITER, 16, number of quotient bits produced; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  16  captured on accepted start.
- divisor  in  16  captured on accepted start.
- busy  out  1  high in SHIFT/SUB states.
- done  out  1  one-cycle pulse; results valid from this cycle.
- quotient  out  16  result, held until next accepted start.
- remainder  out  16  result, held until next accepted start.
- div_by_zero  out  1  set with done when divisor==0; cleared on next accepted start.
- add_a  out  16  datapath operand A (partial remainder low 16 bits).
- add_b  out  16  datapath operand B (raw divisor, not inverted).
- add_sub  out  1  datapath carry-in; 1 = subtract.
- add_en  out  1  datapath enable; high only in SUB.
- add_sum  in  16  datapath result.
- add_cout  in  1  datapath carry-out; 1 = no borrow.
- add_ready  in  1  datapath result valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counter=0; R, r_msb and Q cleared. All outputs 0, including add_a, add_b, add_sub and add_en.
- States: IDLE, SHIFT, SUB, DONE.
- IDLE, start=1, divisor!=0: latch D=divisor, Q=dividend, R=0, counter=0, clear div_by_zero; next state SHIFT.
- IDLE, start=1, divisor==0: latch nothing into R/Q datapath; quotient=16'hFFFF, remainder=dividend, div_by_zero=1; next state DONE.
- IDLE, start=0: remain in IDLE.
- SHIFT (1 cycle): {r_msb,R} <= {R,Q[15]}; Q <= Q<<1; next state SUB.
- SUB outputs: add_a=R, add_b=D, add_sub=1, add_en=1. Outside SUB, add_a/add_b hold their last value and add_en=add_sub=0.
- SUB, add_ready=0: hold the state and all registers, keep datapath outputs stable; no timeout.
- SUB, add_ready=1: success = r_msb | add_cout. The 17-bit trial subtract ignores the lost borrow when r_msb=1.
- On success: R <= add_sum, Q[0] <= 1. Otherwise R is unchanged and Q[0] stays 0.
- After the SUB commit, r_msb <= 0 and counter increments.
- counter==15 at commit: next state DONE, quotient <= Q (including the new bit), remainder <= R (post-commit). Otherwise next state SHIFT.
- DONE (1 cycle): done=1, busy=0; next state IDLE. Start is ignored here.
- Latency with add_ready always high: start sampled at edge T, done high in the cycle after edge T+32 (2 cycles per bit).
- Divide-by-zero path: done high in the cycle after edge T+1.
- Each add_ready-low cycle adds exactly one cycle of latency.
- start while busy or in DONE: ignored, never queued. Inputs may change freely after the accepting edge.
- Reset mid-operation: immediate abort. Outputs return to reset values and the old results are lost.

Test Plan:
- dividend=100, divisor=7, add_ready=1 -> done 33 cycles after start; quotient=14, remainder=2, div_by_zero=0; busy high for exactly 32 cycles.
- dividend=16'hFFFF, divisor=16'h8001 (exercises the r_msb path) -> quotient=1, remainder=16'h7FFE. Separately, 16'hFFFF / 1 -> quotient=16'hFFFF, remainder=0.
- dividend=1234, divisor=0 -> done 2 cycles after start; quotient=16'hFFFF, remainder=1234, div_by_zero=1; add_en never asserts.
- 100/7 with add_ready forced low for 5 cycles in the 3rd SUB -> done at cycle 38. add_a=R, add_b=7 and add_sub=1 stay stable through the stall; result 14 r 2.
- start pulsed at cycles 5 and 20 of a 50/3 run, then start in the DONE cycle -> all three ignored; single done; quotient=16, remainder=2.
- rst_n low at cycle 10 of a division -> all outputs 0 asynchronously. A new start of 9/4 afterwards -> quotient=2, remainder=1 after 33 cycles.

Source files
------------

// File: rtl/addsub_div_seq.sv
// Unsigned restoring divider that sequences a shared external add/subtract datapath.
// One quotient bit costs a SHIFT cycle plus a SUB cycle (longer while add_ready is low).
module addsub_div_seq #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
    output logic             add_en,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    input  logic             add_ready,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_SUB   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic             r_msb;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_dbz;
    logic             r_zero_wait;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;

    logic             w_zero;
    logic             w_success;
    logic             w_last;

    assign w_zero    = (divisor == '0);
    // A set r_msb means the 17-bit partial remainder already exceeds any divisor.
    assign w_success = r_msb | add_cout;
    assign w_last    = (r_cnt == CW'(ITER - 1));

    assign quotient    = r_quot;
    assign remainder   = r_remd;
    assign div_by_zero = r_dbz;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshake: start is taken only in IDLE; add_sum/add_cout are consumed
    // only in a cycle where add_en=1 and add_ready=1, operands stay stable until then.
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        add_en  = 1'b0;
        add_sub = 1'b0;
        add_a   = r_add_a;
        add_b   = r_add_b;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy   = 1'b1;
                w_next = S_SUB;
            end
            S_SUB: begin
                busy    = 1'b1;
                add_en  = 1'b1;
                add_sub = 1'b1;
                add_a   = r_rem;
                add_b   = r_d;
                if (add_ready) begin
                    w_next = w_last ? S_DONE : S_SHIFT;
                end
            end
            S_DONE: begin
                // Divide-by-zero spends one silent cycle here so done lands one edge later.
                done = ~r_zero_wait;
                if (!r_zero_wait) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_msb       <= 1'b0;
            r_q         <= '0;
            r_d         <= '0;
            r_quot      <= '0;
            r_remd      <= '0;
            r_dbz       <= 1'b0;
            r_zero_wait <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_zero) begin
                            r_quot      <= '1;
                            r_remd      <= dividend;
                            r_dbz       <= 1'b1;
                            r_zero_wait <= 1'b1;
                        end else begin
                            r_d   <= divisor;
                            r_q   <= dividend;
                            r_rem <= '0;
                            r_msb <= 1'b0;
                            r_cnt <= '0;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    {r_msb, r_rem} <= {r_rem, r_q[WIDTH-1]};
                    r_q            <= r_q << 1;
                end
                S_SUB: begin
                    r_add_a <= r_rem;
                    r_add_b <= r_d;
                    if (add_ready) begin
                        if (w_success) begin
                            r_rem  <= add_sum;
                            r_q[0] <= 1'b1;
                        end
                        r_msb <= 1'b0;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quot <= {r_q[WIDTH-1:1], w_success};
                            r_remd <= w_success ? add_sum : r_rem;
                        end
                    end
                end
                S_DONE: begin
                    r_zero_wait <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_div_seq.sv
// Directed bench for addsub_div_seq with a behavioural add/subtract datapath.
module tb_addsub_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_sub;
    logic        add_en;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        add_ready;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    addsub_div_seq #(.WIDTH(16), .ITER(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sub    (add_sub),
        .add_en     (add_en),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .add_ready  (add_ready),
        .dbg_state  (dbg_state)
    );

    // clock / datapath model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b ^ {16{add_sub}}} + {16'd0, add_sub};
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_outs"}, {busy, done, div_by_zero, add_sub, add_en, dbg_state}, 32'd0);
        check_val({tag, "_quot"}, {16'd0, quotient}, 32'd0);
        check_val({tag, "_rem"}, {16'd0, remainder}, 32'd0);
        check_val({tag, "_add_a"}, {16'd0, add_a}, 32'd0);
        check_val({tag, "_add_b"}, {16'd0, add_b}, 32'd0);
    endtask

    // Runs one division; optional stall in one SUB and optional ignored start pulses.
    task automatic run_div(input string tag, input logic [15:0] dd, input logic [15:0] dv,
                           input int stall_sub, input int stall_len, input bit noise,
                           input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                           input int elat, input int ebusy);
        int cyc;
        int busy_cnt;
        int en_cnt;
        int sub_num;
        int stall_left;
        int done_cnt;
        bit prev_en;
        bit seen;
        logic [15:0] hold_a;
        logic [15:0] want_q;
        logic [15:0] want_r;
        cyc = 0; busy_cnt = 0; en_cnt = 0; sub_num = 0; done_cnt = 0;
        stall_left = stall_len; prev_en = 1'b0; seen = 1'b0; hold_a = '0;
        exp_q.push_back(eq);
        exp_q.push_back(er);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start     = (noise && (cyc == 5 || cyc == 20)) ? 1'b1 : 1'b0;
            dividend  = 16'hDEAD;
            divisor   = 16'hBEEF;
            add_ready = 1'b1;
            if (busy) busy_cnt++;
            if (add_en) en_cnt++;
            if (add_en && !prev_en) sub_num++;
            prev_en = add_en;
            if (add_en && sub_num == stall_sub && stall_left > 0) begin
                if (stall_left == stall_len) hold_a = add_a;
                check_val({tag, "_stall_a"}, {16'd0, add_a}, {16'd0, hold_a});
                check_val({tag, "_stall_b"}, {15'd0, add_b, add_sub}, {15'd0, dv, 1'b1});
                add_ready = 1'b0;
                stall_left--;
            end
            if (done) seen = 1'b1;
        end
        check_val({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        want_q = exp_q.pop_front();
        want_r = exp_q.pop_front();
        check_val({tag, "_latency"}, cyc, elat);
        check_val({tag, "_quot"}, {16'd0, quotient}, {16'd0, want_q});
        check_val({tag, "_rem"}, {16'd0, remainder}, {16'd0, want_r});
        check_val({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
        check_val({tag, "_busy_cycles"}, busy_cnt, ebusy);
        if (dv == 16'd0) check_val({tag, "_add_en_cnt"}, en_cnt, 0);
        if (noise) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            busy_cnt = 0;
            repeat (40) begin
                @(negedge clk);
                if (busy) busy_cnt++;
                if (done) done_cnt++;
            end
            check_val({tag, "_post_busy"}, busy_cnt, 0);
            check_val({tag, "_post_done"}, done_cnt, 0);
            check_val({tag, "_held_quot"}, {16'd0, quotient}, {16'd0, eq});
        end
        @(negedge clk);
        add_ready = 1'b1;
    endtask

    initial begin
        start = 1'b0; dividend = '0; divisor = '0; add_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        #20 rst_n = 1'b1;

        run_div("d100_7", 16'd100, 16'd7, 0, 0, 1'b0, 16'd14, 16'd2, 1'b0, 33, 32);
        run_div("ffff_8001", 16'hFFFF, 16'h8001, 0, 0, 1'b0, 16'd1, 16'h7FFE, 1'b0, 33, 32);
        run_div("ffff_1", 16'hFFFF, 16'd1, 0, 0, 1'b0, 16'hFFFF, 16'd0, 1'b0, 33, 32);
        run_div("div0", 16'd1234, 16'd0, 0, 0, 1'b0, 16'hFFFF, 16'd1234, 1'b1, 2, 0);
        run_div("stall", 16'd100, 16'd7, 3, 5, 1'b0, 16'd14, 16'd2, 1'b0, 38, 37);
        run_div("noise", 16'd50, 16'd3, 0, 0, 1'b1, 16'd16, 16'd2, 1'b0, 33, 32);

        // Abort a 100/7 run at cycle 10 with an asynchronous reset.
        @(negedge clk);
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_div("d9_4", 16'd9, 16'd4, 0, 0, 1'b0, 16'd2, 16'd1, 1'b0, 33, 32);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
